ps_alter_arbiter: RTL
=====================

# ps_alter_arbiter

Arbitrates all requests to overwrite the architectural program state and sequences the resulting update into the program-state register. Requesters are trap, interrupt, CSR-write and debug logic. At most one request is accepted per cycle. The block drives the register's single alter/value pair, and can enforce a post-update flush window during which no further updates are accepted. It sits between the commit/trap logic and the program-state register in the core.

## Interface
- NUM_REQ, default 4: number of requesters. Index 0 is the trap source (absolute priority); indices 1..NUM_REQ-1 share round-robin. Legal range 2..8.
- FLUSH_CYCLES, default 3: cycles of blocked acceptance after a flushing update. A value of 0 disables the flush window.

- i_clk  input  1  core clock. Single clock domain.
- i_rst  input  1  reset, synchronous, active-high.
- i_req_valid  input  NUM_REQ  per-requester request valid.
- i_req_ps  input  NUM_REQ x program_state_t  per-requester new program state.
- i_req_flush  input  NUM_REQ  per-requester flag: this update requires a pipeline flush.
- o_req_ready  output  NUM_REQ  per-requester grant. A transfer occurs when valid & ready. One-hot or zero.
- i_stall  input  1  when high, no request is granted.
- o_alter  output  1  one-cycle pulse that writes o_ps into the program-state register.
- o_ps  output  program_state_t  state value to write. Holds its last value when o_alter is low.
- o_flush  output  1  one-cycle pulse, coincident with o_alter, for flushing updates.
- o_busy  output  1  high while in the FLUSH state.

## Operation
- FSM states are IDLE and FLUSH.
- In IDLE, with i_stall low, the block grants exactly one valid requester:
  - i_req_valid[0] wins unconditionally.
  - Otherwise the first valid index among 1..NUM_REQ-1 wins, scanning circularly from rr_ptr.
- o_req_ready is combinational from i_req_valid, state, rr_ptr and i_stall.
  - A ready bit is never high for a requester whose valid is low.
  - All ready bits are 0 in FLUSH and whenever i_stall=1.
- rr_ptr update:
  - After a grant to index k≥1, rr_ptr becomes k+1, wrapping from NUM_REQ-1 to 1.
  - A grant to index 0 leaves rr_ptr unchanged.
- On a grant in cycle T:
  - o_ps is registered from i_req_ps[k].
  - o_alter=1 in cycle T+1.
  - o_flush=i_req_flush[k] in cycle T+1.
- If the granted request has its flush flag set and FLUSH_CYCLES>0:
  - The state moves to FLUSH at the edge ending cycle T.
  - The flush counter loads FLUSH_CYCLES.
  - The counter decrements each cycle in FLUSH, and the state returns to IDLE when the counter reaches 1→0.
  - Total blocked cycles are T+1 .. T+FLUSH_CYCLES. The next grant is possible in cycle T+FLUSH_CYCLES+1.
- A request with its flush flag clear, or FLUSH_CYCLES=0, stays in IDLE. A new grant is then possible in cycle T+1, giving back-to-back updates at one per cycle.
- Requesters must hold valid and payload stable until granted. The arbiter keeps no request storage.
- i_stall only blocks new grants. It does not cancel o_alter/o_flush for a grant already made, and it does not pause the flush counter.

## Timing
- Reset values (i_rst sampled high at an edge):
  - state=IDLE, flush counter=0, rr_ptr=1.
  - o_alter=0, o_flush=0, o_busy=0, o_ps='0.
  - o_req_ready=0 while i_rst is high.
- Reset asserted mid-FLUSH returns to IDLE next cycle and drops any pending o_alter.
- Grant-to-alter latency is exactly 1 cycle. o_alter is never high for two consecutive cycles unless two grants occur in consecutive cycles.
- When trap and another requester are valid in the same cycle, trap is granted. The other requester keeps valid and is granted in a later cycle.
- A trap arriving during FLUSH waits; the flush window is not preempted.
- Counter width is $clog2(FLUSH_CYCLES+1).
- o_busy equals (state==FLUSH).

## Test plan
- Reset: hold i_rst for 2 cycles with all valids high -> o_req_ready=0, o_alter=0 and o_ps=0 throughout. First grant after release goes to index 0.
- Priority: valid[0]=valid[2]=1 in cycle 5, no flush -> ready[0]=1 in cycle 5 and o_alter with req 0 payload in cycle 6. Then ready[2]=1 in cycle 6 and o_alter with req 2 payload in cycle 7.
- Round-robin: valid[1..3] held high, no flush -> grants in order 1,2,3,1,2,3 on consecutive cycles, with o_alter high for 6 consecutive cycles.
- Flush window: FLUSH_CYCLES=3, req 1 granted with flush=1 in cycle 10 -> o_flush=o_alter=1 in cycle 11, o_busy high cycles 11–13, no ready in 11–13 despite valid[0]=1, and req 0 granted in cycle 14.
- Stall: i_stall=1 cycles 20–22 with valid[2]=1 -> no ready in those cycles. Ready[2]=1 in cycle 23 and o_alter in cycle 24. A grant made in cycle 19 still produces o_alter in cycle 20.
- Reset mid-flush: i_rst in cycle 12 of the flush scenario -> o_busy=0 and o_alter=0 in cycle 13, and grants resume in cycle 13 after release.

Source files
------------

// File: rtl/ps_alter_arbiter_if.sv
// ps_alter_arbiter_if
//   Groups the request/grant handshake and the program-state write port of
//   ps_alter_arbiter into one bundle.
//   Requester side : req_valid, req_ps, req_flush, stall  -> arbiter
//                    req_ready                            <- arbiter
//   Register side  : alter, ps, flush, busy               <- arbiter
//   Modports: slave  = the arbiter itself
//             master = whatever drives requests and observes the write port
interface ps_alter_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int PS_W    = 32
);
    typedef logic [PS_W-1:0] program_state_t;

    logic           [NUM_REQ-1:0] req_valid;
    program_state_t [NUM_REQ-1:0] req_ps;
    logic           [NUM_REQ-1:0] req_flush;
    logic           [NUM_REQ-1:0] req_ready;
    logic                         stall;
    logic                         alter;
    program_state_t               ps;
    logic                         flush;
    logic                         busy;

    modport slave (
        input  req_valid, req_ps, req_flush, stall,
        output req_ready, alter, ps, flush, busy
    );

    modport master (
        output req_valid, req_ps, req_flush, stall,
        input  req_ready, alter, ps, flush, busy
    );
endinterface

// File: rtl/ps_alter_arbiter.sv
// ps_alter_arbiter
//   Arbitrates requests to overwrite the architectural program state and
//   sequences the winning update into the program-state register.
//   Requester 0 (trap) has absolute priority; 1..NUM_REQ-1 share round-robin.
//   A flushing update can block further grants for FLUSH_CYCLES cycles.
// Ports:
//   i_clk  core clock
//   i_rst  synchronous active-high reset
//   bus    ps_alter_arbiter_if.slave (requests, grants, alter/ps/flush/busy)
module ps_alter_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int FLUSH_CYCLES = 3,
    parameter int PS_W         = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    ps_alter_arbiter_if.slave    bus
);
    localparam int PW = $clog2(NUM_REQ);
    // A zero-length window still needs a legal 1-bit counter.
    localparam int CW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t            state;
    logic [CW-1:0]     flush_cnt;
    logic [PW-1:0]     rr_ptr;
    logic              alter_q;
    logic              flush_q;
    logic [PS_W-1:0]   ps_q;

    logic              gnt_any;
    logic [PW-1:0]     gnt_idx;
    logic [PW-1:0]     scan_idx;

    // Grant selection. The round-robin scan covers indices 1..NUM_REQ-1
    // starting at rr_ptr and wraps back to 1, never to 0.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        if (!i_rst && state == IDLE && !bus.stall) begin
            if (bus.req_valid[0]) begin
                gnt_any = 1'b1;
                gnt_idx = '0;
            end else begin
                for (int o = 0; o < NUM_REQ - 1; o++) begin
                    if (int'(rr_ptr) + o > NUM_REQ - 1)
                        scan_idx = PW'(int'(rr_ptr) + o - (NUM_REQ - 1));
                    else
                        scan_idx = PW'(int'(rr_ptr) + o);
                    if (!gnt_any && bus.req_valid[scan_idx]) begin
                        gnt_any = 1'b1;
                        gnt_idx = scan_idx;
                    end
                end
            end
        end
    end

    assign bus.req_ready = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign bus.alter     = alter_q;
    assign bus.flush     = flush_q;
    assign bus.ps        = ps_q;
    assign bus.busy      = (state == FLUSH);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            flush_cnt <= '0;
            rr_ptr    <= PW'(1);
            alter_q   <= 1'b0;
            flush_q   <= 1'b0;
            ps_q      <= '0;
        end else begin
            alter_q <= gnt_any;
            flush_q <= gnt_any && bus.req_flush[gnt_idx];
            if (gnt_any)
                ps_q <= bus.req_ps[gnt_idx];

            // Trap grants do not disturb the round-robin position.
            if (gnt_any && gnt_idx != '0)
                rr_ptr <= (gnt_idx == PW'(NUM_REQ - 1)) ? PW'(1) : gnt_idx + PW'(1);

            case (state)
                IDLE: begin
                    if (gnt_any && bus.req_flush[gnt_idx] && FLUSH_CYCLES > 0) begin
                        state     <= FLUSH;
                        flush_cnt <= CW'(FLUSH_CYCLES);
                    end
                end
                FLUSH: begin
                    // Counts regardless of stall; leaves on the 1->0 step.
                    flush_cnt <= flush_cnt - CW'(1);
                    if (flush_cnt == CW'(1))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
